// File: rtl/lag_pair_average.sv
// rtl/lag_pair_average.sv - frame-buffered pairwise averager with lagged pairing
//
// Collects one frame of DEPTH samples, then streams DEPTH-LAG results
// out[j] = avg(s[j], s[j+LAG]), one per cycle, with no stalls.
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-low reset
//   in_valid  sample present on data this cycle
//   data      input sample, DATA_W bits
//   in_ready  sample accepted this cycle when in_valid is high (fill phase only)
//   round_en  1 = round half up, 0 = truncate; sampled with the last sample of a frame
//   valid     out holds a result this cycle
//   out       averaged result, DATA_W bits; holds its last value while valid is low
//   done      one-cycle pulse alongside the last result of a frame

module lag_pair_average #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 128,
  parameter int LAG    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] data,
  output logic              in_ready,
  input  logic              round_en,
  output logic              valid,
  output logic [DATA_W-1:0] out,
  output logic              done
);

  localparam int AW = $clog2(DEPTH);

  // The last input sample is itself the partner of s[0] only when LAG == DEPTH-1.
  localparam bit FIRST_PAIR_USES_INPUT = (LAG == DEPTH - 1);
  // A frame with a single result finishes on the edge that accepts its last sample.
  localparam bit SINGLE_RESULT = (DEPTH - LAG == 1);

  typedef enum logic {
    FILL,
    EMIT
  } state_t;

  state_t            state;
  logic [AW-1:0]     wr_cnt;
  logic [AW-1:0]     rd_idx;
  logic              mode;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept;
  logic              last_in;
  logic              last_out;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              rnd;
  logic [DATA_W+1:0] sum;
  logic [DATA_W-1:0] avg;

  // Held low through the final result cycle so the next frame starts only
  // once the previous one has fully drained.
  assign in_ready = (state == FILL) && !valid;
  assign accept   = in_valid && in_ready;
  assign last_in  = (wr_cnt == AW'(DEPTH - 1));
  assign last_out = (rd_idx == AW'(DEPTH - LAG - 1));

  // Result 0 is produced on the edge that accepts the final sample, so its
  // operands and rounding mode come straight from the buffer and inputs.
  // Afterwards rd_idx names the pair being produced on the coming edge.
  always_comb begin
    op_a = mem[0];
    op_b = mem[LAG];
    rnd  = round_en;
    if (state == FILL) begin
      if (FIRST_PAIR_USES_INPUT) begin
        op_b = data;
      end
    end else begin
      op_a = mem[rd_idx];
      op_b = mem[rd_idx + AW'(LAG)];
      rnd  = mode;
    end
  end

  assign sum = {2'b00, op_a} + {2'b00, op_b} + {{(DATA_W + 1){1'b0}}, rnd};
  assign avg = sum[DATA_W:1];

  // Sample storage needs no reset: every entry is written before it is read.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_cnt] <= data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= FILL;
      wr_cnt <= '0;
      rd_idx <= '0;
      mode   <= 1'b0;
      valid  <= 1'b0;
      out    <= '0;
      done   <= 1'b0;
    end else begin
      valid <= 1'b0;
      done  <= 1'b0;
      case (state)
        FILL: begin
          if (accept) begin
            if (last_in) begin
              mode  <= round_en;
              out   <= avg;
              valid <= 1'b1;
              if (SINGLE_RESULT) begin
                done   <= 1'b1;
                wr_cnt <= '0;
              end else begin
                state  <= EMIT;
                rd_idx <= AW'(1);
              end
            end else begin
              wr_cnt <= wr_cnt + AW'(1);
            end
          end
        end
        EMIT: begin
          out   <= avg;
          valid <= 1'b1;
          if (last_out) begin
            done   <= 1'b1;
            state  <= FILL;
            wr_cnt <= '0;
            rd_idx <= '0;
          end else begin
            rd_idx <= rd_idx + AW'(1);
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_lag_pair_average.sv
// tb/tb_lag_pair_average.sv - directed self-checking bench for lag_pair_average
//
// Drives the default instance (8-bit, 128 samples, lag 8) through ramp,
// rounding, carry, gapped, back-to-back and reset-abort frames, plus a
// small 4-bit/4-sample/lag-1 instance with hand-computed results.

module tb_lag_pair_average;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       in_valid;
  logic [7:0] data;
  logic       in_ready;
  logic       round_en;
  logic       valid;
  logic [7:0] out;
  logic       done;

  logic       s_in_valid;
  logic [3:0] s_data;
  logic       s_in_ready;
  logic       s_round_en;
  logic       s_valid;
  logic [3:0] s_out;
  logic       s_done;

  int checks = 0;
  int errors = 0;
  int s [128];

  lag_pair_average dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .data     (data),
    .in_ready (in_ready),
    .round_en (round_en),
    .valid    (valid),
    .out      (out),
    .done     (done)
  );

  lag_pair_average #(.DATA_W(4), .DEPTH(4), .LAG(1)) dut_small (
    .clk      (clk),
    .reset    (reset),
    .in_valid (s_in_valid),
    .data     (s_data),
    .in_ready (s_in_ready),
    .round_en (s_round_en),
    .valid    (s_valid),
    .out      (s_out),
    .done     (s_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Fill one frame from s[], then check every result against the pairwise model
  // and the hand-computed first/last values.
  task automatic run_frame(input bit r, input bit gaps, input bit noise,
                           input int first_v, input int last_v);
    int e;
    for (int i = 0; i < 128; i++) begin
      if (gaps && (i % 3 == 1)) begin
        in_valid = 1'b0;
        data     = 8'($urandom);
        round_en = ~r;
        check("gap_valid", valid, 0);
        step();
      end
      in_valid = 1'b1;
      data     = 8'(s[i]);
      round_en = r;
      check("fill_ready", in_ready, 1);
      check("fill_valid", valid, 0);
      step();
    end
    in_valid = noise;
    data     = 8'($urandom);
    round_en = ~r;
    for (int j = 0; j < 120; j++) begin
      e = (s[j] + s[j+8] + int'(r)) >> 1;
      check("emit_valid", valid, 1);
      check("emit_out", out, e);
      check("emit_done", done, (j == 119));
      check("emit_ready", in_ready, 0);
      if (j == 0)   check("first_out", out, first_v);
      if (j == 119) check("last_out", out, last_v);
      data = 8'($urandom);
      step();
    end
    check("post_valid", valid, 0);
    check("post_done", done, 0);
    check("post_ready", in_ready, 1);
    check("post_hold", out, last_v);
    in_valid = 1'b0;
  endtask

  task automatic run_small(input bit r, input int e0, input int e1, input int e2);
    int smp [4] = '{1, 2, 4, 15};
    int ex [3];
    ex[0] = e0; ex[1] = e1; ex[2] = e2;
    for (int i = 0; i < 4; i++) begin
      s_in_valid = 1'b1;
      s_data     = 4'(smp[i]);
      s_round_en = r;
      check("small_ready", s_in_ready, 1);
      step();
    end
    s_in_valid = 1'b1;
    s_data     = 4'hF;
    s_round_en = ~r;
    for (int j = 0; j < 3; j++) begin
      check("small_valid", s_valid, 1);
      check("small_out", s_out, ex[j]);
      check("small_done", s_done, (j == 2));
      check("small_busy", s_in_ready, 0);
      step();
    end
    s_in_valid = 1'b0;
    check("small_post_valid", s_valid, 0);
    check("small_post_ready", s_in_ready, 1);
  endtask

  initial begin
    int seen;
    reset      = 1'b0;
    in_valid   = 1'b0;
    data       = '0;
    round_en   = 1'b0;
    s_in_valid = 1'b0;
    s_data     = '0;
    s_round_en = 1'b0;

    #22;
    check("rst_valid", valid, 0);
    check("rst_out", out, 0);
    check("rst_done", done, 0);
    reset = 1'b1;
    step();
    check("rel_ready", in_ready, 1);
    check("rel_valid", valid, 0);

    // Ramp 0..127, rounding, with noise on the input during results.
    for (int i = 0; i < 128; i++) s[i] = i;
    run_frame(1'b1, 1'b0, 1'b1, 4, 123);
    // Same ramp with gaps, immediately after the previous frame.
    run_frame(1'b1, 1'b1, 1'b0, 4, 123);
    // Back-to-back ramp 10..137.
    for (int i = 0; i < 128; i++) s[i] = i + 10;
    run_frame(1'b1, 1'b0, 1'b1, 14, 133);

    // Rounding boundary: 255 paired with 0.
    for (int i = 0; i < 128; i++) s[i] = (i < 8) ? 255 : 0;
    run_frame(1'b1, 1'b0, 1'b0, 128, 0);
    run_frame(1'b0, 1'b0, 1'b0, 127, 0);

    // Carry: full-scale sum.
    for (int i = 0; i < 128; i++) s[i] = 255;
    run_frame(1'b1, 1'b0, 1'b0, 255, 255);
    run_frame(1'b0, 1'b0, 1'b1, 255, 255);

    // Reset in the middle of the result stream.
    for (int i = 0; i < 128; i++) begin
      in_valid = 1'b1;
      data     = 8'(i);
      round_en = 1'b1;
      step();
    end
    in_valid = 1'b0;
    for (int j = 0; j < 50; j++) step();
    check("pre_rst_valid", valid, 1);
    check("pre_rst_out", out, 54);
    reset = 1'b0;
    #1;
    check("async_valid", valid, 0);
    check("async_out", out, 0);
    check("async_done", done, 0);
    #2;
    reset = 1'b1;
    step();
    check("abort_ready", in_ready, 1);
    // Partial frame must produce nothing.
    for (int i = 0; i < 60; i++) begin
      in_valid = 1'b1;
      data     = 8'(i);
      step();
    end
    in_valid = 1'b0;
    seen = 0;
    for (int k = 0; k < 150; k++) begin
      if (valid) seen++;
      step();
    end
    check("partial_no_output", seen, 0);
    reset = 1'b0;
    #3;
    reset = 1'b1;
    step();
    for (int i = 0; i < 128; i++) s[i] = i;
    run_frame(1'b1, 1'b0, 1'b0, 4, 123);

    // Small instance: DEPTH=4, LAG=1, DATA_W=4.
    run_small(1'b1, 2, 3, 10);
    run_small(1'b0, 1, 3, 9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
